// File: rtl/result_copy_pkg.sv
// Shared types and widths for the result copy scheduler and its arbiter.
package result_copy_pkg;

  typedef enum logic [2:0] {
    IDLE,
    KICK,
    WAIT_START,
    WAIT_END,
    DONE,
    ERROR
  } state_e;

  localparam int OFFSET_W = 32;
  localparam int WORDS_W  = 32;
  localparam int ADDR_W   = 64;

  localparam int DEFAULT_NUM_REQ        = 4;
  localparam int DEFAULT_TIMEOUT_CYCLES = 1048576;

endpackage

// File: rtl/result_copy_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from ptr_i+1 with wrap
// and returns a one-hot grant plus its index.
module rr_arbiter
  import result_copy_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic                       enable_i,
  input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
  output logic [NUM_REQ-1:0]         grant_o,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx_o
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic found;
  int   cand;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    cand        = 0;
    if (enable_i) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        cand = (int'(ptr_i) + k) % NUM_REQ;
        if (!found && req_i[cand]) begin
          found         = 1'b1;
          grant_o[cand] = 1'b1;
          grant_idx_o   = IDX_W'(cand);
        end
      end
    end
  end

endmodule

// File: rtl/result_copy_scheduler.sv
// Shares one result-copy engine between NUM_REQ producers: round-robin job
// acceptance, engine kick/busy tracking, completion strobes and a watchdog.
module result_copy_scheduler
  import result_copy_pkg::*;
#(
  parameter int NUM_REQ        = DEFAULT_NUM_REQ,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*OFFSET_W-1:0]  req_offset,
  input  logic [NUM_REQ*WORDS_W-1:0]   req_words,
  input  logic [NUM_REQ*ADDR_W-1:0]    req_memory_addr,
  output logic [NUM_REQ-1:0]           done_pulse,
  output logic                         copy_kick,
  input  logic                         copy_busy,
  output logic [OFFSET_W-1:0]          copy_offset,
  output logic [WORDS_W-1:0]           copy_words,
  output logic [ADDR_W-1:0]            copy_memory_addr,
  output logic                         busy,
  output logic [31:0]                  jobs_done,
  output logic                         err_timeout,
  input  logic                         clear_err
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);

  state_e               state_q;
  logic [IDX_W-1:0]     rr_ptr_q;
  logic [IDX_W-1:0]     grant_q;
  logic [WDOG_W-1:0]    wdog_q;
  logic [WDOG_W-1:0]    wdog_d;
  logic                 copy_kick_q;
  logic [NUM_REQ-1:0]   done_pulse_q;
  logic [OFFSET_W-1:0]  copy_offset_q;
  logic [WORDS_W-1:0]   copy_words_q;
  logic [ADDR_W-1:0]    copy_addr_q;
  logic [31:0]          jobs_done_q;
  logic                 err_q;

  logic                 arb_en;
  logic                 accept;
  logic [NUM_REQ-1:0]   win;
  logic [IDX_W-1:0]     win_idx;
  logic [OFFSET_W-1:0]  sel_offset;
  logic [WORDS_W-1:0]   sel_words;
  logic [ADDR_W-1:0]    sel_addr;

  // The engine reports busy while it is still coming out of reset, so no
  // grant is offered until it is genuinely idle.
  assign arb_en = (state_q == IDLE) && !copy_busy && !reset;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i       (req_valid),
    .enable_i    (arb_en),
    .ptr_i       (rr_ptr_q),
    .grant_o     (win),
    .grant_idx_o (win_idx)
  );

  assign req_ready  = win;
  assign accept     = |(req_valid & win);
  assign sel_offset = req_offset[int'(win_idx)*OFFSET_W +: OFFSET_W];
  assign sel_words  = req_words[int'(win_idx)*WORDS_W +: WORDS_W];
  assign sel_addr   = req_memory_addr[int'(win_idx)*ADDR_W +: ADDR_W];
  assign wdog_d     = wdog_q + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      rr_ptr_q      <= IDX_W'(NUM_REQ - 1);
      grant_q       <= '0;
      wdog_q        <= '0;
      copy_kick_q   <= 1'b0;
      done_pulse_q  <= '0;
      copy_offset_q <= '0;
      copy_words_q  <= '0;
      copy_addr_q   <= '0;
      jobs_done_q   <= '0;
      err_q         <= 1'b0;
    end else begin
      copy_kick_q  <= 1'b0;
      done_pulse_q <= '0;
      if (clear_err) err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            copy_offset_q <= sel_offset;
            copy_words_q  <= sel_words;
            copy_addr_q   <= sel_addr;
            grant_q       <= win_idx;
            if (sel_words == '0) begin
              state_q <= DONE;
            end else begin
              state_q     <= KICK;
              copy_kick_q <= 1'b1;
            end
          end
        end
        KICK: begin
          wdog_q  <= '0;
          state_q <= WAIT_START;
        end
        WAIT_START, WAIT_END: begin
          if (wdog_d == WDOG_W'(TIMEOUT_CYCLES)) begin
            err_q   <= 1'b1;
            state_q <= ERROR;
          end else begin
            wdog_q <= wdog_d;
            if (state_q == WAIT_START && copy_busy)  state_q <= WAIT_END;
            if (state_q == WAIT_END   && !copy_busy) state_q <= DONE;
          end
        end
        DONE: begin
          done_pulse_q[grant_q] <= 1'b1;
          jobs_done_q           <= jobs_done_q + 32'd1;
          rr_ptr_q              <= grant_q;
          state_q               <= IDLE;
        end
        ERROR: begin
          if (clear_err) begin
            rr_ptr_q <= grant_q;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign copy_kick        = copy_kick_q;
  assign done_pulse       = done_pulse_q;
  assign copy_offset      = copy_offset_q;
  assign copy_words       = copy_words_q;
  assign copy_memory_addr = copy_addr_q;
  assign jobs_done        = jobs_done_q;
  assign err_timeout      = err_q;
  assign busy             = (state_q != IDLE);

endmodule

// File: tb/tb_result_copy_scheduler.sv
// Self-checking bench for result_copy_scheduler with a behavioural engine
// and a round-robin reference model.
module tb_result_copy_scheduler;

  localparam int N   = 4;
  localparam int TMO = 64;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*32-1:0] req_offset;
  logic [N*32-1:0] req_words;
  logic [N*64-1:0] req_memory_addr;
  logic [N-1:0]    done_pulse;
  logic            copy_kick;
  logic            copy_busy;
  logic [31:0]     copy_offset;
  logic [31:0]     copy_words;
  logic [63:0]     copy_memory_addr;
  logic            busy;
  logic [31:0]     jobs_done;
  logic            err_timeout;
  logic            clear_err;

  int errors = 0;
  int checks = 0;

  logic engBusy;
  logic engForce = 1'b0;
  logic engHang  = 1'b0;
  int   engLen   = 4;
  int   engRemain;

  int cycle         = 0;
  int kickCount     = 0;
  int lastKickCycle = 0;
  int lastDoneCycle = 0;
  int doneQ[$];

  result_copy_scheduler #(.NUM_REQ(N), .TIMEOUT_CYCLES(TMO)) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_offset       (req_offset),
    .req_words        (req_words),
    .req_memory_addr  (req_memory_addr),
    .done_pulse       (done_pulse),
    .copy_kick        (copy_kick),
    .copy_busy        (copy_busy),
    .copy_offset      (copy_offset),
    .copy_words       (copy_words),
    .copy_memory_addr (copy_memory_addr),
    .busy             (busy),
    .jobs_done        (jobs_done),
    .err_timeout      (err_timeout),
    .clear_err        (clear_err)
  );

  always #5 clk = ~clk;

  // Engine model: busy rises the cycle after a kick and stays high engLen cycles.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      engBusy   <= 1'b0;
      engRemain <= 0;
    end else if (copy_kick && !engHang) begin
      engBusy   <= 1'b1;
      engRemain <= engLen - 1;
    end else if (engBusy) begin
      if (engRemain == 0) engBusy <= 1'b0;
      else engRemain <= engRemain - 1;
    end
  end
  assign copy_busy = engBusy | engForce;

  always @(negedge clk) begin
    cycle = cycle + 1;
    if (copy_kick) begin
      kickCount     = kickCount + 1;
      lastKickCycle = cycle;
    end
    for (int i = 0; i < N; i++) begin
      if (done_pulse[i]) begin
        doneQ.push_back(i);
        lastDoneCycle = cycle;
      end
    end
  end

  function automatic int rrPick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic setJob(input int i, input logic [31:0] off, input logic [31:0] w,
                        input logic [63:0] a);
    req_offset[i*32 +: 32]      = off;
    req_words[i*32 +: 32]       = w;
    req_memory_addr[i*64 +: 64] = a;
  endtask

  task automatic doReset();
    reset     = 1'b1;
    req_valid = '0;
    clear_err = 1'b0;
    engHang   = 1'b0;
    engForce  = 1'b0;
    step();
    step();
    reset = 1'b0;
    doneQ.delete();
    step();
  endtask

  task automatic waitDone(input int bound, output int idx, output bit ok);
    ok  = 1'b0;
    idx = -1;
    for (int i = 0; i < bound; i++) begin
      if (doneQ.size() > 0) begin
        idx = doneQ.pop_front();
        ok  = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    req_valid = '0;
    step();
    checks++;
    if ({busy, copy_kick, done_pulse, err_timeout, req_ready} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl busy=%b kick=%b done=%b err=%b ready=%b required all 0",
               busy, copy_kick, done_pulse, err_timeout, req_ready);
    end
    checks++;
    if ({copy_offset, copy_words, copy_memory_addr, jobs_done} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_data off=%h words=%h addr=%h jobs=%0d required 0",
               copy_offset, copy_words, copy_memory_addr, jobs_done);
    end
    reset = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0 || req_ready !== '0) begin
      errors++;
      $display("[TB] FAIL reset_release busy=%b ready=%b required 0/0", busy, req_ready);
    end
  endtask

  task automatic test_single_job();
    int k0, idx;
    bit ok;
    doReset();
    engLen = 30;
    k0 = kickCount;
    setJob(0, 32'h10, 32'd20, 64'h1000);
    req_valid = 4'b0001;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL single_ready got=%b required 0001", req_ready);
    end
    step();
    req_valid = '0;
    waitDone(200, idx, ok);
    checks++;
    if (!ok || idx != 0) begin
      errors++;
      $display("[TB] FAIL single_done idx=%0d ok=%0d required idx 0", idx, ok);
    end
    checks++;
    if (kickCount - k0 != 1 || lastDoneCycle - lastKickCycle != 33) begin
      errors++;
      $display("[TB] FAIL single_timing kicks=%0d kick_to_done=%0d required 1 and 33",
               kickCount - k0, lastDoneCycle - lastKickCycle);
    end
    checks++;
    if (copy_offset !== 32'h10 || copy_words !== 32'd20 || copy_memory_addr !== 64'h1000 ||
        jobs_done !== 32'd1) begin
      errors++;
      $display("[TB] FAIL single_fields off=%h words=%0d addr=%h jobs=%0d required 10/20/1000/1",
               copy_offset, copy_words, copy_memory_addr, jobs_done);
    end
  endtask

  task automatic test_fairness();
    int last, pick, got;
    bit multi, ok;
    int order[$];
    doReset();
    engLen = 2;
    last   = N - 1;
    multi  = 1'b0;
    for (int i = 0; i < N; i++) setJob(i, 32'(i * 16), 32'(i + 1), 64'(i * 4096));
    req_valid = '1;
    #1;
    for (int j = 0; j < 8; j++) begin
      ok  = 1'b0;
      got = -1;
      for (int c = 0; c < 60 && !ok; c++) begin
        if ($countones(req_ready) > 1) multi = 1'b1;
        if ((req_ready & req_valid) != '0) begin
          ok = 1'b1;
          for (int k = 0; k < N; k++) if (req_ready[k]) got = k;
        end else begin
          step();
        end
      end
      pick = rrPick(req_valid, last);
      order.push_back(pick);
      checks++;
      if (got != pick) begin
        errors++;
        $display("[TB] FAIL fair_grant job=%0d got=%0d required %0d", j, got, pick);
      end
      last = pick;
      step();
    end
    req_valid = '0;
    for (int c = 0; c < 100 && doneQ.size() < 8; c++) step();
    checks++;
    if (doneQ != order) begin
      errors++;
      $display("[TB] FAIL fair_done_order got=%p required %p", doneQ, order);
    end
    checks++;
    if (multi) begin
      errors++;
      $display("[TB] FAIL fair_onehot multiple ready bits seen, required at most one");
    end
  endtask

  task automatic test_zero_words();
    int k0, acc, idx;
    bit ok;
    doReset();
    k0 = kickCount;
    setJob(2, 32'h55, 32'd0, 64'hABC);
    req_valid = 4'b0100;
    #1;
    acc = cycle;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++;
      $display("[TB] FAIL zero_ready got=%b required 0100", req_ready);
    end
    step();
    req_valid = '0;
    waitDone(20, idx, ok);
    checks++;
    if (!ok || idx != 2 || lastDoneCycle - acc != 2) begin
      errors++;
      $display("[TB] FAIL zero_done idx=%0d latency=%0d required idx 2 latency 2",
               idx, lastDoneCycle - acc);
    end
    checks++;
    if (kickCount != k0 || jobs_done !== 32'd1 || copy_offset !== 32'h55) begin
      errors++;
      $display("[TB] FAIL zero_state kicks=%0d jobs=%0d off=%h required 0 kicks, 1 job, off 55",
               kickCount - k0, jobs_done, copy_offset);
    end
  endtask

  task automatic test_busy_after_reset();
    bit seen;
    int idx;
    bit ok;
    reset     = 1'b1;
    engForce  = 1'b1;
    req_valid = '0;
    step();
    step();
    reset = 1'b0;
    doneQ.delete();
    engLen = 3;
    setJob(1, 32'h7, 32'd5, 64'h2000);
    req_valid = 4'b0010;
    seen = 1'b0;
    for (int c = 0; c < 50; c++) begin
      step();
      if (req_ready !== '0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("[TB] FAIL busy_hold ready seen while engine busy, required 0");
    end
    engForce = 1'b0;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL busy_release_ready got=%b required 0010", req_ready);
    end
    step();
    req_valid = '0;
    waitDone(50, idx, ok);
    checks++;
    if (!ok || idx != 1) begin
      errors++;
      $display("[TB] FAIL busy_release_done idx=%0d required 1", idx);
    end
  endtask

  task automatic test_watchdog();
    int k0, errCyc, idx;
    bit ok;
    doReset();
    engHang = 1'b1;
    setJob(1, 32'h11, 32'd7, 64'h3000);
    setJob(2, 32'h22, 32'd3, 64'h4000);
    req_valid = 4'b0010;
    #1;
    step();
    req_valid = '0;
    k0 = lastKickCycle;
    errCyc = -1;
    for (int c = 0; c < 200; c++) begin
      step();
      if (err_timeout === 1'b1) begin
        errCyc = cycle;
        break;
      end
    end
    checks++;
    if (errCyc < 0 || errCyc - k0 < TMO || errCyc - k0 > TMO + 1) begin
      errors++;
      $display("[TB] FAIL wdog_time kick_to_err=%0d required %0d..%0d", errCyc - k0, TMO, TMO + 1);
    end
    req_valid = 4'b0110;
    step();
    step();
    checks++;
    if (req_ready !== '0 || doneQ.size() != 0 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL wdog_error_state ready=%b dones=%0d busy=%b required 0/0/1",
               req_ready, doneQ.size(), busy);
    end
    engHang   = 1'b0;
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    #1;
    checks++;
    if (err_timeout !== 1'b0 || req_ready !== 4'b0100) begin
      errors++;
      $display("[TB] FAIL wdog_clear err=%b ready=%b required 0 and 0100", err_timeout, req_ready);
    end
    step();
    req_valid = '0;
    waitDone(50, idx, ok);
    checks++;
    if (!ok || idx != 2) begin
      errors++;
      $display("[TB] FAIL wdog_next_done idx=%0d required 2", idx);
    end
  endtask

  task automatic test_reset_mid_job();
    int idx;
    bit ok;
    doReset();
    engLen = 40;
    setJob(3, 32'h33, 32'd9, 64'h5000);
    req_valid = 4'b1000;
    #1;
    step();
    req_valid = '0;
    for (int c = 0; c < 10; c++) step();
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, copy_kick, done_pulse, err_timeout} !== '0 || copy_words !== '0 ||
        jobs_done !== '0) begin
      errors++;
      $display("[TB] FAIL midreset_outputs busy=%b kick=%b done=%b words=%0d required 0",
               busy, copy_kick, done_pulse, copy_words);
    end
    step();
    step();
    reset = 1'b0;
    for (int c = 0; c < 5; c++) step();
    checks++;
    if (doneQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL midreset_nodone dones=%0d required 0", doneQ.size());
    end
    engLen = 4;
    setJob(0, 32'h44, 32'd4, 64'h6000);
    req_valid = 4'b0001;
    #1;
    step();
    req_valid = '0;
    waitDone(50, idx, ok);
    checks++;
    if (!ok || idx != 0 || jobs_done !== 32'd1) begin
      errors++;
      $display("[TB] FAIL midreset_recover idx=%0d jobs=%0d required 0 and 1", idx, jobs_done);
    end
  endtask

  task automatic test_random();
    logic [31:0] offA[N];
    logic [31:0] wordsA[N];
    logic [63:0] addrA[N];
    logic [N-1:0] mask;
    logic [N-1:0] expReady;
    int last, pick, k0, acc, idx, modelJobs;
    bit ok;
    doReset();
    last      = N - 1;
    modelJobs = 0;
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < N; i++) begin
        offA[i]   = $urandom;
        wordsA[i] = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
        addrA[i]  = {$urandom, $urandom};
        setJob(i, offA[i], wordsA[i], addrA[i]);
      end
      engLen    = $urandom_range(1, 8);
      mask      = N'($urandom_range(1, (1 << N) - 1));
      req_valid = mask;
      k0        = kickCount;
      #1;
      acc       = cycle;
      pick      = rrPick(mask, last);
      expReady  = '0;
      expReady[pick] = 1'b1;
      checks++;
      if (req_ready !== expReady) begin
        errors++;
        $display("[TB] FAIL rand_ready round=%0d mask=%b got=%b required %b",
                 r, mask, req_ready, expReady);
      end
      step();
      req_valid = '0;
      waitDone(60, idx, ok);
      modelJobs++;
      last = pick;
      checks++;
      if (!ok || idx != pick || jobs_done !== 32'(modelJobs)) begin
        errors++;
        $display("[TB] FAIL rand_done round=%0d idx=%0d jobs=%0d required %0d and %0d",
                 r, idx, jobs_done, pick, modelJobs);
      end
      checks++;
      if (copy_offset !== offA[pick] || copy_words !== wordsA[pick] ||
          copy_memory_addr !== addrA[pick]) begin
        errors++;
        $display("[TB] FAIL rand_fields round=%0d off=%h words=%h addr=%h required %h %h %h",
                 r, copy_offset, copy_words, copy_memory_addr, offA[pick], wordsA[pick],
                 addrA[pick]);
      end
      checks++;
      if (wordsA[pick] == 32'd0) begin
        if (kickCount != k0 || lastDoneCycle - acc != 2) begin
          errors++;
          $display("[TB] FAIL rand_zero_latency round=%0d kicks=%0d latency=%0d required 0 and 2",
                   r, kickCount - k0, lastDoneCycle - acc);
        end
      end else begin
        if (kickCount - k0 != 1 || lastKickCycle - acc != 1 ||
            lastDoneCycle - lastKickCycle != engLen + 3) begin
          errors++;
          $display("[TB] FAIL rand_job_latency round=%0d kicks=%0d kick_to_done=%0d required 1 and %0d",
                   r, kickCount - k0, lastDoneCycle - lastKickCycle, engLen + 3);
        end
      end
    end
  endtask

  initial begin
    reset           = 1'b1;
    req_valid       = '0;
    req_offset      = '0;
    req_words       = '0;
    req_memory_addr = '0;
    clear_err       = 1'b0;
    test_reset();
    test_single_job();
    test_fairness();
    test_zero_words();
    test_busy_after_reset();
    test_watchdog();
    test_reset_mid_job();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
